// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front-end.
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
      logic               err;
   } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO with flush; the head is held in a register that keeps its last value when empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  entry_t        din,
   output entry_t        dout,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   entry_t mem [DEPTH];
   logic [AW-1:0] rptr, wptr, rnext;
   logic do_pop;
   assign empty  = count == '0;
   assign full   = count == CW'(DEPTH);
   assign do_pop = pop && !empty;
   assign rnext  = rptr + AW'(do_pop);
   always_ff @(posedge clk)
      if (push && !flush) mem[wptr] <= din;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         dout  <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         rptr  <= rnext;
         count <= count + CW'(push) - CW'(do_pop);
         // a push into an empty (or emptying) queue becomes the head directly
         if (push && count == CW'(do_pop)) dout <= din;
         else if (count > CW'(do_pop)) dout <= mem[rnext];
      end
   end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: single-outstanding instruction fetcher feeding a prefetch queue,
// with redirect flush and discard of stale in-flight responses.
module fetch_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [31:0]        imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               imem_rsp_err,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [31:0]        if_pc,
   output logic               if_err,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc
);
   localparam int CW = $clog2(DEPTH) + 1;
   state_t state, state_next;
   logic [31:0] fetch_pc, req_pc;
   logic halted, accept, push, pop, empty, full;
   logic [CW-1:0] count;
   entry_t head;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   // a response always ends the outstanding request; a redirect only marks a pending one stale
   always_comb
      state_next = state == IDLE ? (accept ? WAIT : IDLE) :
                   imem_rsp_valid ? IDLE : redirect_valid ? DROP : state;
   always_comb begin
      imem_req_valid = rst_n && state == IDLE && !halted && !redirect_valid && count < CW'(DEPTH);
      imem_req_addr  = fetch_pc;
   end
   assign accept = imem_req_valid && imem_req_ready;
   assign push   = state == WAIT && imem_rsp_valid && !redirect_valid;
   assign pop    = if_valid && if_ready && !redirect_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         halted   <= 1'b0;
      end else begin
         fetch_pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc + PC_STEP : fetch_pc;
         if (accept) req_pc <= fetch_pc;
         halted <= redirect_valid ? 1'b0 : (push && imem_rsp_err) ? 1'b1 : halted;
      end
   end
   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ('{pc: req_pc, instr: imem_rsp_data, err: imem_rsp_err}),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );
   assign if_valid = !empty;
   assign if_instr = head.instr;
   assign if_pc    = head.pc;
   assign if_err   = head.err;
   a_rsp_idle: assert property (@(posedge clk) disable iff (!rst_n) !(state == IDLE && imem_rsp_valid));
   a_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed scenarios against a latency-configurable memory model.
module tb_fetch_prefetch_queue;
   logic clk = 0, rst_n = 0;
   logic imem_req_valid, imem_req_ready = 0;
   logic [31:0] imem_req_addr;
   logic imem_rsp_valid = 0, imem_rsp_err = 0;
   logic [31:0] imem_rsp_data = 0;
   logic if_valid, if_ready = 0, if_err;
   logic [31:0] if_instr, if_pc;
   logic redirect_valid = 0;
   logic [31:0] redirect_pc = 0;
   int errors = 0, checks = 0;
   int lat = 1, cnt = 0;
   logic pend = 0;
   logic [31:0] paddr = 0, err_addr = 32'hFFFF_FFFF;
   logic [31:0] acc_q[$];
   logic [64:0] log_q[$];

   function automatic logic [31:0] idata(input logic [31:0] a);
      return 32'h1300_0000 | a;
   endfunction

   always #5 clk = ~clk;

   fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_err(if_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   // memory model and consumer log: decisions made at negedge for the following rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 0;
         imem_rsp_valid = 0;
         imem_rsp_err = 0;
      end else begin
         if (if_valid && if_ready && !redirect_valid) log_q.push_back({if_pc, if_instr, if_err});
         imem_rsp_valid = 0;
         imem_rsp_err = 0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rsp_valid = 1;
               imem_rsp_data = idata(paddr);
               imem_rsp_err = paddr == err_addr;
               pend = 0;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            acc_q.push_back(imem_req_addr);
            pend = 1;
            cnt = lat;
            paddr = imem_req_addr;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 0;
      imem_req_ready = 0;
      if_ready = 0;
      redirect_valid = 0;
      lat = 1;
      err_addr = 32'hFFFF_FFFF;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1;
      acc_q.delete();
      log_q.delete();
   endtask

   task automatic wait_log(input int n, input string nm);
      int k = 0;
      while (log_q.size() < n && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      checks++;
      if (log_q.size() < n) begin
         errors++;
         $display("FAIL %s: log size %0d, expected at least %0d", nm, log_q.size(), n);
      end
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks += 2;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
      if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
      tick;
      rst_n = 1;
      @(negedge clk);
      checks += 6;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid: got %b expected 1", imem_req_valid); end
      if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rel_req_addr: got %h expected 0", imem_req_addr); end
      if (if_valid !== 1'b0) begin errors++; $display("FAIL rel_if_valid: got %b expected 0", if_valid); end
      if (if_instr !== 32'h0) begin errors++; $display("FAIL rel_if_instr: got %h expected 0", if_instr); end
      if (if_pc !== 32'h0) begin errors++; $display("FAIL rel_if_pc: got %h expected 0", if_pc); end
      if (if_err !== 1'b0) begin errors++; $display("FAIL rel_if_err: got %b expected 0", if_err); end
   endtask

   task automatic test_streaming;
      do_reset;
      if_ready = 1;
      imem_req_ready = 1;
      wait_log(6, "stream_count");
      imem_req_ready = 0;
      for (int i = 0; i < log_q.size(); i++) begin
         logic [31:0] p;
         p = 32'(i * 4);
         checks++;
         if (log_q[i] !== {p, idata(p), 1'b0}) begin
            errors++;
            $display("FAIL stream_entry%0d: got %h expected %h", i, log_q[i], {p, idata(p), 1'b0});
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset;
      imem_req_ready = 1;
      repeat (20) tick;
      @(negedge clk);
      checks += 4;
      if (acc_q.size() !== 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", acc_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL bp_addr%0d: got %h expected %h", i, acc_q[i], 32'(i * 4)); end
      end
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
      if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_if_valid: got %b expected 1", if_valid); end
      if (if_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", if_pc); end
      tick;
      if_ready = 1;
      tick;
      if_ready = 0;
      @(negedge clk);
      checks += 3;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_pop_req_valid: got %b expected 1", imem_req_valid); end
      if (imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_pop_addr: got %h expected 10", imem_req_addr); end
      if (if_pc !== 32'h4) begin errors++; $display("FAIL bp_pop_head: got %h expected 4", if_pc); end
   endtask

   task automatic test_redirect;
      int k = 0;
      do_reset;
      lat = 3;
      if_ready = 1;
      imem_req_ready = 1;
      while (acc_q.size() < 3 && k < 100) begin @(negedge clk); #1; k++; end
      tick;
      checks++;
      if (acc_q.size() !== 3 || acc_q[2] !== 32'h8) begin errors++; $display("FAIL rd_setup: accepted %0d requests, expected third at 8", acc_q.size()); end
      redirect_valid = 1;
      redirect_pc = 32'h103;
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_withdraw: got %b expected 0", imem_req_valid); end
      tick;
      redirect_valid = 0;
      log_q.delete();
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: if_valid got %b expected 0", if_valid); end
      k = 0;
      while (!imem_req_valid && k < 20) begin @(negedge clk); #1; k++; end
      checks += 2;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rd_restart: req_valid got %b expected 1", imem_req_valid); end
      if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL rd_addr: got %h expected 100", imem_req_addr); end
      wait_log(1, "rd_log");
      if (log_q.size() > 0) begin
         checks++;
         if (log_q[0] !== {32'h100, idata(32'h100), 1'b0}) begin errors++; $display("FAIL rd_first: got %h expected %h", log_q[0], {32'h100, idata(32'h100), 1'b0}); end
      end
   endtask

   task automatic test_fault;
      int bad = 0;
      do_reset;
      err_addr = 32'h10;
      if_ready = 1;
      imem_req_ready = 1;
      wait_log(5, "flt_log");
      if (log_q.size() >= 5) begin
         checks += 2;
         if (log_q[4] !== {32'h10, idata(32'h10), 1'b1}) begin errors++; $display("FAIL flt_entry: got %h expected %h", log_q[4], {32'h10, idata(32'h10), 1'b1}); end
         if (log_q[3] !== {32'hC, idata(32'hC), 1'b0}) begin errors++; $display("FAIL flt_prev: got %h expected %h", log_q[3], {32'hC, idata(32'hC), 1'b0}); end
      end
      repeat (20) begin
         @(negedge clk);
         if (imem_req_valid) bad++;
      end
      checks += 2;
      if (bad != 0) begin errors++; $display("FAIL flt_halt: req_valid high %0d cycles, expected 0", bad); end
      if (acc_q.size() !== 5) begin errors++; $display("FAIL flt_accepts: got %0d expected 5", acc_q.size()); end
      tick;
      redirect_valid = 1;
      redirect_pc = 32'h40;
      tick;
      redirect_valid = 0;
      @(negedge clk);
      checks += 2;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL flt_resume: got %b expected 1", imem_req_valid); end
      if (imem_req_addr !== 32'h40) begin errors++; $display("FAIL flt_addr: got %h expected 40", imem_req_addr); end
   endtask

   task automatic test_simultaneous;
      int k = 0;
      do_reset;
      lat = 2;
      imem_req_ready = 1;
      while (!(acc_q.size() >= 2 && imem_rsp_valid && if_valid) && k < 100) begin @(negedge clk); #1; k++; end
      checks++;
      if (!(imem_rsp_valid && if_valid)) begin errors++; $display("FAIL sim_setup: rsp_valid %b if_valid %b, expected both 1", imem_rsp_valid, if_valid); end
      if_ready = 1;
      redirect_valid = 1;
      redirect_pc = 32'h200;
      tick;
      redirect_valid = 0;
      log_q.delete();
      @(negedge clk);
      checks += 3;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL sim_flush: if_valid got %b expected 0", if_valid); end
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL sim_idle: req_valid got %b expected 1", imem_req_valid); end
      if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL sim_addr: got %h expected 200", imem_req_addr); end
      wait_log(1, "sim_log");
      if (log_q.size() > 0) begin
         checks++;
         if (log_q[0] !== {32'h200, idata(32'h200), 1'b0}) begin errors++; $display("FAIL sim_first: got %h expected %h", log_q[0], {32'h200, idata(32'h200), 1'b0}); end
      end
   endtask

   initial begin
      test_reset;
      test_streaming;
      test_backpressure;
      test_redirect;
      test_fault;
      test_simultaneous;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
